// File: rtl/param_updown_counter_pkg.sv
// Shared encodings and helpers for the parametrised up/down counter.
// Imported by the next-state calculator and the counter top.
package param_updown_counter_pkg;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  localparam logic WRAP = 1'b0;
  localparam logic SAT  = 1'b1;

endpackage

// File: rtl/param_updown_next.sv
// Combinational next-count and boundary-event calculator.
// All arithmetic is WIDTH+1 bits so max_val+1 never overflows.
module param_updown_next
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] dout,
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] max_val,
  input  logic             mode,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt,
  output logic             evt
);

  localparam int NW = WIDTH + 1;

  logic [WIDTH:0] cur;
  logic [WIDTH:0] mx;
  logic [WIDTH:0] mp1;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign cur = NW'(dout);
  assign mx  = NW'(max_val);
  assign mp1 = mx + NW'(1);
  assign sum = cur + s;
  assign dif = cur + mp1 - s;

  always_comb begin
    nxt = dout;
    evt = 1'b0;
    // A lowered bound pulls a stale count back into range first.
    if (cur > mx) begin
      nxt = max_val;
      evt = 1'b1;
    end else if (s == '0) begin
      nxt = dout;
      evt = 1'b0;
    end else if (mode == UP) begin
      if (sum <= mx) begin
        nxt = WIDTH'(sum);
      end else if (sat == SAT) begin
        nxt = max_val;
        evt = (cur != mx);
      end else begin
        nxt = WIDTH'(sum - mp1);
        evt = 1'b1;
      end
    end else begin
      if (s <= cur) begin
        nxt = WIDTH'(cur - s);
      end else if (sat == SAT) begin
        nxt = '0;
        evt = (cur != '0);
      end else begin
        nxt = WIDTH'(dif);
        evt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Loadable up/down counter with programmable step, bound and
// wrap/saturate policy; registered count and boundary-event pulse.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int STEP_W      = 3,
  parameter int SAT_DEFAULT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              mode,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              tc,
  output logic              evt
);

  localparam int NW = WIDTH + 1;
  localparam int EW = (STEP_W > NW) ? STEP_W : NW;

  // sat is expected to be tied to SAT_DEFAULT (0 or 1) by integrators.
  if (SAT_DEFAULT != 0 && SAT_DEFAULT != 1) begin : g_sat_default_invalid
  end

  logic [EW-1:0]    step_x;
  logic [EW-1:0]    mx_x;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] nxt;
  logic             nxt_evt;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] dout_q;
  logic             evt_q;

  assign step_x = EW'(step);
  assign mx_x   = EW'(max_val);
  assign s      = (step_x > mx_x) ? NW'(mx_x) : NW'(step_x);
  assign ld_val = (din > max_val) ? max_val : din;

  param_updown_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .dout    (dout_q),
    .s       (s),
    .max_val (max_val),
    .mode    (mode),
    .sat     (sat),
    .nxt     (nxt),
    .evt     (nxt_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      evt_q  <= 1'b0;
    end else if (load) begin
      dout_q <= ld_val;
      evt_q  <= 1'b0;
    end else if (en) begin
      dout_q <= nxt;
      evt_q  <= nxt_evt;
    end else begin
      evt_q  <= 1'b0;
    end
  end

  assign dout = dout_q;
  assign evt  = evt_q;
  assign tc   = (mode == UP) ? (dout_q == max_val) : (dout_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter.
// Each task drives one scenario and checks against hand-computed values.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic       mode;
  logic       sat;
  logic [2:0] step;
  logic [4:0] max_val;
  logic [4:0] din;
  logic [4:0] dout;
  logic       tc;
  logic       evt;

  int checks   = 0;
  int failures = 0;

  param_updown_counter #(
    .WIDTH       (5),
    .STEP_W      (3),
    .SAT_DEFAULT (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .mode    (mode),
    .sat     (sat),
    .step    (step),
    .max_val (max_val),
    .din     (din),
    .dout    (dout),
    .tc      (tc),
    .evt     (evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] v);
    load = 1'b1;
    din  = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0; sat = 1'b0;
    step = 3'd0; max_val = 5'd20; din = 5'd0;
    #12;
    checks++;
    if (dout !== 5'd0) begin
      failures++;
      $display("FAIL reset_dout got=%0d exp=0", dout);
    end
    checks++;
    if (evt !== 1'b0) begin
      failures++;
      $display("FAIL reset_evt got=%0b exp=0", evt);
    end
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL reset_tc_down got=%0b exp=1", tc);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_clamp();
    mode = 1'b1; max_val = 5'd20;
    do_load(5'd31);
    checks++;
    if (dout !== 5'd20) begin
      failures++;
      $display("FAIL load_clamp got=%0d exp=20", dout);
    end
    checks++;
    if (tc !== 1'b1 || evt !== 1'b0) begin
      failures++;
      $display("FAIL load_clamp_flags got tc=%0b evt=%0b exp tc=1 evt=0",
               tc, evt);
    end
  endtask

  task automatic test_up_wrap();
    int   exp_d[4] = '{3, 6, 9, 2};
    logic exp_e[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_t[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    max_val = 5'd9; mode = 1'b1; sat = 1'b0; step = 3'd3;
    do_load(5'd0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dout !== 5'(exp_d[i]) || evt !== exp_e[i] || tc !== exp_t[i]) begin
        failures++;
        $display("FAIL up_wrap[%0d] got d=%0d e=%0b t=%0b exp d=%0d e=%0b t=%0b",
                 i, dout, evt, tc, exp_d[i], exp_e[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_sat();
    int   exp_d[4] = '{2, 0, 0, 0};
    logic exp_e[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    max_val = 5'd9; mode = 1'b0; sat = 1'b1; step = 3'd4;
    do_load(5'd6);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dout !== 5'(exp_d[i]) || evt !== exp_e[i] || tc !== exp_t[i]) begin
        failures++;
        $display("FAIL down_sat[%0d] got d=%0d e=%0b t=%0b exp d=%0d e=%0b t=%0b",
                 i, dout, evt, tc, exp_d[i], exp_e[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_up_sat_hold();
    max_val = 5'd9; mode = 1'b1; sat = 1'b1; step = 3'd2;
    do_load(5'd9);
    en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (dout !== 5'd9 || evt !== 1'b0) begin
      failures++;
      $display("FAIL up_sat_at_max got d=%0d e=%0b exp d=9 e=0", dout, evt);
    end
  endtask

  task automatic test_full_range();
    max_val = 5'd31; step = 3'd1; sat = 1'b0; mode = 1'b1;
    do_load(5'd31);
    en = 1'b1;
    tick();
    checks++;
    if (dout !== 5'd0 || evt !== 1'b1) begin
      failures++;
      $display("FAIL full_up_wrap got d=%0d e=%0b exp d=0 e=1", dout, evt);
    end
    mode = 1'b0;
    tick();
    checks++;
    if (dout !== 5'd31 || evt !== 1'b1) begin
      failures++;
      $display("FAIL full_down_wrap got d=%0d e=%0b exp d=31 e=1", dout, evt);
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    max_val = 5'd20; mode = 1'b1; sat = 1'b0; step = 3'd3;
    en = 1'b1;
    do_load(5'd5);
    en = 1'b0;
    checks++;
    if (dout !== 5'd5 || evt !== 1'b0) begin
      failures++;
      $display("FAIL load_over_en got d=%0d e=%0b exp d=5 e=0", dout, evt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dout !== 5'd5 || evt !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d] got d=%0d e=%0b exp d=5 e=0", i, dout, evt);
      end
    end
    step = 3'd0; en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (dout !== 5'd5 || evt !== 1'b0) begin
      failures++;
      $display("FAIL step_zero got d=%0d e=%0b exp d=5 e=0", dout, evt);
    end
  endtask

  task automatic test_step_clamp();
    max_val = 5'd4; mode = 1'b1; sat = 1'b0; step = 3'd7;
    do_load(5'd0);
    en = 1'b1;
    tick();
    checks++;
    if (dout !== 5'd4 || evt !== 1'b0) begin
      failures++;
      $display("FAIL step_clamp got d=%0d e=%0b exp d=4 e=0", dout, evt);
    end
    tick();
    checks++;
    if (dout !== 5'd3 || evt !== 1'b1) begin
      failures++;
      $display("FAIL step_clamp_wrap got d=%0d e=%0b exp d=3 e=1", dout, evt);
    end
    en = 1'b0;
  endtask

  task automatic test_bound_and_async_reset();
    max_val = 5'd20; mode = 1'b1; sat = 1'b0; step = 3'd1;
    do_load(5'd15);
    max_val = 5'd10; en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (dout !== 5'd10 || evt !== 1'b1) begin
      failures++;
      $display("FAIL bound_reduce got d=%0d e=%0b exp d=10 e=1", dout, evt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== 5'd0 || evt !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got d=%0d e=%0b exp d=0 e=0", dout, evt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_clamp();
    test_up_wrap();
    test_down_sat();
    test_up_sat_hold();
    test_full_range();
    test_priority();
    test_step_clamp();
    test_bound_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
